// File: rtl/data_sync_pkg.sv
// Types and constants shared by the data_sync subsystem: the arbiter state set,
// the common data width, and the tag width derived from the requester count.
package data_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DW_DEFAULT   = 8;
  localparam int NREQ_DEFAULT = 4;
  localparam int TAG_W        = $clog2(NREQ_DEFAULT);

  // Index width for n requesters, never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/data_sync_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first requester after last_i,
// wrapping modulo N.
module rr_pick
  import data_sync_pkg::*;
#(
  parameter int N  = NREQ_DEFAULT,
  parameter int TW = tag_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] last_i,
  output logic [TW-1:0] grant_o,
  output logic          any_o
);

  logic [TW-1:0] cand_s;

  // Scan from the farthest candidate down to the nearest so the nearest valid one wins.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    cand_s  = '0;
    for (int k = N; k >= 1; k--) begin
      cand_s = TW'((int'(last_i) + k) % N);
      if (req_i[cand_s]) begin
        grant_o = cand_s;
        any_o   = 1'b1;
      end else begin
        any_o   = any_o;
      end
    end
  end

endmodule

// File: rtl/data_sync_arbiter.sv
// Round-robin sequencer sharing one data_sync among NREQ producers, with bursts
// capped at MAX_BURST beats and each synchronised word tagged by its source.
module data_sync_arbiter
  import data_sync_pkg::*;
#(
  parameter int NREQ      = NREQ_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int MAX_BURST = 4,
  localparam int TW       = tag_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [DW-1:0]      sync_din,
  output logic               sync_dready,
  input  logic               sync_dready_o,
  output logic [TW-1:0]      out_tag,
  output logic               out_valid,
  output logic               busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  state_e         state_q, state_d;
  logic [TW-1:0]  owner_q, owner_d;
  logic [TW-1:0]  last_q, last_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]  tag_q, tag_d;
  logic [TW-1:0]  grant_s;
  logic           any_s;
  logic           beat_s;

  rr_pick #(.N(NREQ), .TW(TW)) u_pick (
    .req_i   (req_valid),
    .last_i  (last_q),
    .grant_o (grant_s),
    .any_o   (any_s)
  );

  // Handshake is gated by rst so a reset cycle never transfers a beat.
  assign beat_s    = !rst && (state_q == XFER) && req_valid[owner_q];
  assign out_valid = sync_dready_o;
  assign out_tag   = tag_q;
  assign busy      = (state_q != IDLE);

  // Drive the owner's handshake and data onto data_sync while transferring.
  always_comb begin
    req_ready   = '0;
    sync_dready = 1'b0;
    sync_din    = '0;
    if (!rst && (state_q == XFER)) begin
      req_ready[owner_q] = 1'b1;
      sync_dready        = req_valid[owner_q];
      if (req_valid[owner_q]) begin
        sync_din = req_data[int'(owner_q) * DW +: DW];
      end else begin
        sync_din = '0;
      end
    end else begin
      req_ready = '0;
    end
  end

  // Next-state logic for arbitration, burst counting and tag alignment.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          owner_d = grant_s;
          cnt_d   = '0;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (beat_s) begin
          cnt_d = cnt_q + BCW'(1);
          tag_d = owner_q;
          if (cnt_q == LAST_BEAT) begin
            state_d = GAP;
            last_d  = owner_q;
          end else begin
            state_d = XFER;
          end
        end else begin
          state_d = GAP;
          last_d  = owner_q;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; last_owner resets to NREQ-1 so requester 0 goes first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= TW'(NREQ - 1);
      cnt_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: tb/tb_data_sync_arbiter.sv
// Randomised bench for data_sync_arbiter with a data_sync stand-in, a grant
// reference model and a scoreboard matching tagged words at the output.
module tb_data_sync_arbiter;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;
  localparam int TW        = 2;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      sync_din;
  logic               sync_dready;
  logic               ds_rdy;
  logic [DW-1:0]      ds_dout;
  logic [TW-1:0]      out_tag;
  logic               out_valid;
  logic               busy;

  data_sync_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .sync_din      (sync_din),
    .sync_dready   (sync_dready),
    .sync_dready_o (ds_rdy),
    .out_tag       (out_tag),
    .out_valid     (out_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_sync stand-in: one registered stage, reset from the same rst.
  always @(posedge clk) begin
    if (rst) begin
      ds_dout <= '0;
      ds_rdy  <= 1'b0;
    end else begin
      ds_dout <= sync_din;
      ds_rdy  <= sync_dready;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: phase 0 = arbitrate, 1 = granted, 2 = gap.
  int          ph, own, last, nbeats;
  logic [TW-1:0] etag;
  logic [7:0]  word [NREQ];
  logic [15:0] sbq [$];

  task automatic model_step();
    int exp_ready, exp_dr, exp_din;
    bit found;
    if (rst) begin
      check("ready_rst", req_ready, 0);
      check("dready_rst", sync_dready, 0);
      check("din_rst", sync_din, 0);
      ph = 0; own = 0; last = NREQ - 1; nbeats = 0; etag = '0;
      return;
    end
    exp_ready = (ph == 1) ? (1 << own) : 0;
    exp_dr    = (ph == 1 && req_valid[own]) ? 1 : 0;
    exp_din   = exp_dr ? int'(word[own]) : 0;
    check("req_ready", req_ready, exp_ready);
    check("sync_dready", sync_dready, exp_dr);
    check("sync_din", sync_din, exp_din);
    check("busy", busy, (ph != 0) ? 1 : 0);
    check("out_tag", out_tag, etag);
    if (ph == 0) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req_valid[(last + k) % NREQ]) begin
          own = (last + k) % NREQ;
          found = 1'b1;
        end
      end
      if (found) begin
        ph = 1;
        nbeats = 0;
      end
    end else if (ph == 1) begin
      if (req_valid[own]) begin
        sbq.push_back({8'(own), word[own]});
        word[own] = word[own] + 8'd1;
        etag = TW'(own);
        nbeats++;
        if (nbeats == MAX_BURST) begin
          ph = 2;
          last = own;
        end
      end else begin
        ph = 2;
        last = own;
      end
    end else begin
      ph = 0;
    end
  endtask

  task automatic run_cycle(input logic [NREQ-1:0] mask, input int prob, input logic do_rst);
    @(negedge clk);
    rst = do_rst;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = mask[i] && ($urandom_range(99) < prob);
      req_data[i*DW +: DW] = req_valid[i] ? word[i] : 8'($urandom);
    end
    #1;
    model_step();
  endtask

  // Monitor: every word data_sync presents must match the oldest expected beat.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("dout", ds_dout, e[7:0]);
          check("tag", out_tag, e[15:8]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    ph = 0; own = 0; last = NREQ - 1; nbeats = 0; etag = '0;
    for (int i = 0; i < NREQ; i++) word[i] = 8'(i * 8'h11);
    word[0] = 8'hA5;
    word[2] = 8'h10;
    repeat (2) run_cycle(4'b0000, 0, 1'b1);
    repeat (4) run_cycle(4'b0000, 0, 1'b0);
    repeat (30) run_cycle(4'b0001, 40, 1'b0);
    repeat (30) run_cycle(4'b0100, 100, 1'b0);
    word[0] = 8'h00;
    word[1] = 8'h11;
    word[2] = 8'h22;
    word[3] = 8'h33;
    repeat (2) run_cycle(4'b1111, 100, 1'b1);
    repeat (50) run_cycle(4'b1111, 100, 1'b0);
    repeat (40) run_cycle(4'b1010, 80, 1'b0);
    repeat (300) run_cycle(4'b1111, 60, 1'b0);
    repeat (400) run_cycle(4'($urandom), 75, ($urandom_range(99) < 3));
    repeat (10) run_cycle(4'b0000, 0, 1'b0);
    check("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
